// File: rtl/logic_gate_stream_if.sv
// Valid/ready stream bundle for the logic gate unit.
// The master side is the upstream producer (and downstream acceptor); the slave side is the unit itself.
interface logic_gate_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_beats
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_y, out_beats
  );
endinterface

// File: rtl/logic_gate_stream.sv
// Registered two-operand bitwise logic unit with single-beat and packet-accumulate modes.
// Results leave through a one-entry output register with valid/ready.
module logic_gate_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_gate_stream_if.slave    bus
);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic             in_ready;
  logic             fire;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] gate_r;
  logic [WIDTH-1:0] comb_g;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (op)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = ~(a ^ b);
      3'd6:    y = a & ~b;
      default: y = a;
    endcase
    return y;
  endfunction

  // Reduction operator paired with each gate: AND-family, OR-family, XOR-family, or replace.
  function automatic logic [WIDTH-1:0] combine_fn(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] y;
    case (op)
      3'd0, 3'd3, 3'd6: y = acc & r;
      3'd1, 3'd4:       y = acc | r;
      3'd2, 3'd5:       y = acc ^ r;
      default:          y = r;
    endcase
    return y;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign fire     = bus.in_valid && in_ready;
  assign op_eff   = (state_q == ACCUM) ? op_q : bus.in_op;
  assign gate_r   = gate_fn(op_eff, bus.in_a, bus.in_b);
  assign comb_g   = combine_fn(op_q, acc_q, gate_r);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_beats = out_beats_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire && bus.in_acc && !bus.in_last) state_d = ACCUM;
      ACCUM:   if (fire && bus.in_last)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_y_d     = out_y_q;
    out_beats_d = out_beats_q;
    // A transferred result clears valid unless a new one replaces it below.
    out_valid_d = out_valid_q && !bus.out_ready;
    if (fire) begin
      case (state_q)
        IDLE: begin
          if (!bus.in_acc || bus.in_last) begin
            out_y_d     = gate_r;
            out_beats_d = CNT_W'(1);
            out_valid_d = 1'b1;
          end else begin
            op_d  = bus.in_op;
            acc_d = gate_r;
            cnt_d = CNT_W'(1);
          end
        end
        ACCUM: begin
          if (bus.in_last) begin
            out_y_d     = comb_g;
            out_beats_d = sat_inc(cnt_q);
            out_valid_d = 1'b1;
          end else begin
            acc_d = comb_g;
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_beats_q <= '0;
    end else begin
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_beats_q <= out_beats_d;
    end
  end

endmodule

// File: tb/tb_logic_gate_stream.sv
// Scoreboard bench: two units (8-bit and 2-bit beat counters) share one input stream.
module tb_logic_gate_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_gate_stream_if #(.WIDTH(8), .CNT_W(8)) v1 ();
  logic_gate_stream_if #(.WIDTH(8), .CNT_W(2)) v2 ();

  assign v2.in_valid  = v1.in_valid;
  assign v2.in_a      = v1.in_a;
  assign v2.in_b      = v1.in_b;
  assign v2.in_op     = v1.in_op;
  assign v2.in_acc    = v1.in_acc;
  assign v2.in_last   = v1.in_last;
  assign v2.out_ready = v1.out_ready;

  logic_gate_stream #(.WIDTH(8), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(v1));
  logic_gate_stream #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(v2));

  typedef struct {
    logic [7:0] y;
    int         beats;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic [7:0] y, input int beats);
    exp_t e1, e2;
    e1.y = y; e1.beats = beats;
    e2.y = y; e2.beats = (beats > 3) ? 3 : beats;
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  // Scoreboard monitor: compare every transferred result against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (v1.out_valid && v1.out_ready) begin
      if (q1.size() == 0) chk("dut1 unexpected output", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 out_y", {24'd0, v1.out_y}, {24'd0, e.y});
        chk("dut1 out_beats", {24'd0, v1.out_beats}, e.beats);
      end
    end
    if (v2.out_valid && v2.out_ready) begin
      if (q2.size() == 0) chk("dut2 unexpected output", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        chk("dut2 out_y", {24'd0, v2.out_y}, {24'd0, e.y});
        chk("dut2 out_beats", {30'd0, v2.out_beats}, e.beats);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the unit accepts it; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic acc, input logic last);
    int n;
    v1.in_a = a; v1.in_b = b; v1.in_op = op; v1.in_acc = acc; v1.in_last = last;
    v1.in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!v1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    v1.in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] exp_single [8];
    exp_single = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
    v1.in_valid = 1'b0; v1.in_a = '0; v1.in_b = '0; v1.in_op = '0;
    v1.in_acc = 1'b0; v1.in_last = 1'b0; v1.out_ready = 1'b1;

    // Power-on reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready during rst", {31'd0, v1.in_ready}, 32'd0);
    chk("out_valid after rst", {31'd0, v1.out_valid}, 32'd0);
    chk("out_y after rst", {24'd0, v1.out_y}, 32'd0);
    chk("out_beats after rst", {24'd0, v1.out_beats}, 32'd0);
    chk("dut2 out_beats after rst", {30'd0, v2.out_beats}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single mode, all eight gates, back to back
    for (int op = 0; op < 8; op++) begin
      expect_out(exp_single[op], 1);
      send(8'hF0, 8'h3C, 3'(op), 1'b0, 1'b0);
      chk("single latency out_valid", {31'd0, v1.out_valid}, 32'd1);
    end

    // Accumulate XOR packet; op/acc changes mid-packet must be ignored
    expect_out(8'h07, 3);
    send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0);
    send(8'h02, 8'h00, 3'd5, 1'b0, 1'b0);
    send(8'h04, 8'h00, 3'd0, 1'b0, 1'b1);
    idle(1);

    // Backpressure: pending result held, input stalled, then no bubble on release
    v1.out_ready = 1'b0;
    expect_out(8'h0F, 1);
    send(8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0);
    v1.in_a = 8'h10; v1.in_b = 8'h01; v1.in_op = 3'd1; v1.in_acc = 1'b0; v1.in_last = 1'b0;
    v1.in_valid = 1'b1;
    expect_out(8'h11, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall in_ready", {31'd0, v1.in_ready}, 32'd0);
      chk("stall out_y held", {24'd0, v1.out_y}, 32'h0F);
      @(posedge clk); #1;
    end
    v1.out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", {31'd0, v1.in_ready}, 32'd1);
    @(posedge clk); #1;
    v1.in_valid = 1'b0;
    @(negedge clk);
    chk("no bubble out_valid", {31'd0, v1.out_valid}, 32'd1);
    @(posedge clk); #1;

    // Counter saturation: six AND beats; 2-bit counter clips at 3
    expect_out(8'hFF, 6);
    for (int i = 0; i < 6; i++) send(8'hFF, 8'hFF, 3'd0, 1'b1, (i == 5));

    // One-beat accumulate packet stays in IDLE: a following single beat answers immediately
    expect_out(8'h81, 1);
    send(8'h80, 8'h01, 3'd1, 1'b1, 1'b1);
    expect_out(8'h5A, 1);
    send(8'h5A, 8'h00, 3'd7, 1'b0, 1'b0);
    chk("single after 1-beat packet", {31'd0, v1.out_valid}, 32'd1);

    // Reset mid-ACCUM discards the open packet
    send(8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready during mid-packet rst", {31'd0, v1.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("out_valid after mid-packet rst", {31'd0, v1.out_valid}, 32'd0);
    expect_out(8'h0F, 1);
    send(8'h0F, 8'h00, 3'd2, 1'b1, 1'b1);
    idle(2);

    // Reset with a pending output discards it
    v1.out_ready = 1'b0;
    send(8'h33, 8'h00, 3'd7, 1'b0, 1'b0);
    idle(1);
    chk("pending out_valid", {31'd0, v1.out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready during pending rst", {31'd0, v1.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("out_valid after pending rst", {31'd0, v1.out_valid}, 32'd0);
    chk("out_y after pending rst", {24'd0, v1.out_y}, 32'd0);
    chk("out_beats after pending rst", {24'd0, v1.out_beats}, 32'd0);
    v1.out_ready = 1'b1;
    idle(3);

    chk("dut1 scoreboard drained", q1.size(), 32'd0);
    chk("dut2 scoreboard drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
